mux_scan_arbiter: RTL and testbench

Sequencer stage upstream of the 8-channel 4-bit behavioural multiplexer. Arbitrates among eight request lines round-robin, drives the multiplexer's select inputs s2/s1/s0, samples the returned 4-bit nibble one cycle later, and delivers it with its channel number on a valid/ready output. Each transfer acknowledges the winning requester with a one-cycle grant pulse.

---
 rtl/mux_scan_arbiter_if.sv | 24 ++
 rtl/mux_scan_arbiter.sv | 102 ++++++++++
 tb/tb_mux_scan_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_arbiter_if.sv
// Bus bundle between the scan arbiter, the 8:1 nibble multiplexer and the downstream sink.
// The arbiter side uses the master modport; the environment side uses the slave modport.
interface mux_scan_arbiter_if;
  logic [7:0] req;
  logic [3:0] mux_y;
  logic       s2;
  logic       s1;
  logic       s0;
  logic [7:0] grant;
  logic [3:0] out_data;
  logic [2:0] out_chan;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  req, mux_y, out_ready,
    output s2, s1, s0, grant, out_data, out_chan, out_valid
  );

  modport slave (
    output req, mux_y, out_ready,
    input  s2, s1, s0, grant, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_scan_arbiter.sv
// Round-robin sequencer for an 8-channel 4-bit mux: select, capture one cycle later, deliver on valid/ready.
// Optional macro ARB_FIXED_PRIO_EN: lowest asserted channel always wins instead of round-robin.
module mux_scan_arbiter (
  input  logic                       clk,
  input  logic                       rst_n,
  mux_scan_arbiter_if.master         bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t     r_state;
  logic [2:0] r_sel;
  logic [2:0] r_last;
  logic [7:0] r_grant;
  logic [3:0] r_out_data;
  logic [2:0] r_out_chan;
  logic       r_out_valid;

  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_found;

  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    w_found  = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < 8; k++) begin
      w_idx = 3'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
`else
    // Scan last+1 .. last+8 (mod 8); the last served channel is checked last.
    for (int unsigned k = 1; k <= 8; k++) begin
      w_idx = r_last + 3'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_last      <= 3'd7;
      r_grant     <= '0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_grant <= '0;
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          if (|bus.req) begin
            r_sel   <= w_winner;
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_out_data  <= bus.mux_y;
          r_out_chan  <= r_sel;
          r_out_valid <= 1'b1;
          r_grant     <= 8'b1 << r_sel;
          r_last      <= r_sel;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (|bus.req) begin
              r_sel   <= w_winner;
              r_state <= ST_SAMPLE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s2        = r_sel[2];
  assign bus.s1        = r_sel[1];
  assign bus.s0        = r_sel[0];
  assign bus.grant     = r_grant;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_scan_arbiter.sv
// Directed bench for mux_scan_arbiter (default round-robin build) with a behavioural 8:1 mux model.
module tb_mux_scan_arbiter;

  logic clk;
  logic rst_n;
  logic [3:0] mux_in [8];
  int n_tests;
  int n_fail;

  mux_scan_arbiter_if bus ();

  mux_scan_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.mux_y = mux_in[{bus.s2, bus.s1, bus.s0}];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mux(input bit inv);
    for (int k = 0; k < 8; k++) mux_in[k] = inv ? 4'(15 - k) : 4'(k);
  endtask

  function automatic logic [7:0] sel_now();
    return {5'b0, bus.s2, bus.s1, bus.s0};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    set_mux(1'b0);
    rst_n         = 1'b0;
    bus.req       = 8'hFF;
    bus.out_ready = 1'b0;

    // Reset held with all requests active
    tick();
    tick();
    chk("rst_sel", sel_now(), 8'h00);
    chk("rst_grant", bus.grant, 8'h00);
    chk("rst_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("rst_data", {4'b0, bus.out_data}, 8'h00);
    chk("rst_chan", {5'b0, bus.out_chan}, 8'h00);

    rst_n = 1'b1;
    tick();
    chk("first_sel", sel_now(), 8'h00);
    chk("first_valid_lo", {7'b0, bus.out_valid}, 8'h00);
    tick();
    chk("first_valid", {7'b0, bus.out_valid}, 8'h01);
    chk("first_chan", {5'b0, bus.out_chan}, 8'h00);
    chk("first_grant", bus.grant, 8'h01);
    bus.req       = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    chk("first_done", {7'b0, bus.out_valid}, 8'h00);

    // Single request, channel 5
    bus.req = 8'h20;
    tick();
    chk("single_lat1", {7'b0, bus.out_valid}, 8'h00);
    chk("single_sel", sel_now(), 8'h05);
    tick();
    chk("single_valid", {7'b0, bus.out_valid}, 8'h01);
    chk("single_chan", {5'b0, bus.out_chan}, 8'h05);
    chk("single_data", {4'b0, bus.out_data}, 8'h05);
    chk("single_grant", bus.grant, 8'h20);
    bus.req = 8'h00;
    tick();
    chk("single_grant_off", bus.grant, 8'h00);
    chk("single_idle", {7'b0, bus.out_valid}, 8'h00);

    // Round-robin with all requests, last=5 so scan starts at 6
    set_mux(1'b1);
    bus.req = 8'hFF;
    tick();
    chk("rr_sel0", sel_now(), 8'h06);
    for (int n = 0; n < 9; n++) begin
      logic [2:0] ec;
      ec = 3'((6 + n) % 8);
      tick();
      chk("rr_valid", {7'b0, bus.out_valid}, 8'h01);
      chk("rr_chan", {5'b0, bus.out_chan}, {5'b0, ec});
      chk("rr_data", {4'b0, bus.out_data}, {4'b0, 4'(15 - ec)});
      chk("rr_grant", bus.grant, 8'b1 << ec);
      if (n == 8) bus.req = 8'h00;
      tick();
      chk("rr_gap", {7'b0, bus.out_valid}, 8'h00);
      chk("rr_grant_gap", bus.grant, 8'h00);
    end

    // Wrap and skip: last=6, req=03 -> 0 then 1; req drops during SAMPLE of 1
    bus.req = 8'h03;
    tick();
    chk("wrap_sel", sel_now(), 8'h00);
    tick();
    chk("wrap_chan0", {5'b0, bus.out_chan}, 8'h00);
    chk("wrap_data0", {4'b0, bus.out_data}, 8'h0F);
    chk("wrap_grant0", bus.grant, 8'h01);
    bus.req = 8'h02;
    tick();
    chk("wrap_sel1", sel_now(), 8'h01);
    bus.req = 8'h00;
    tick();
    chk("wrap_valid1", {7'b0, bus.out_valid}, 8'h01);
    chk("wrap_chan1", {5'b0, bus.out_chan}, 8'h01);
    chk("wrap_data1", {4'b0, bus.out_data}, 8'h0E);
    chk("wrap_grant1", bus.grant, 8'h02);
    tick();
    chk("wrap_idle", {7'b0, bus.out_valid}, 8'h00);

    // Backpressure on channel 3, mux input changes during the stall
    bus.req       = 8'h08;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("bp_chan", {5'b0, bus.out_chan}, 8'h03);
    chk("bp_data", {4'b0, bus.out_data}, 8'h0C);
    chk("bp_grant", bus.grant, 8'h08);
    bus.req   = 8'h80;
    mux_in[3] = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", {7'b0, bus.out_valid}, 8'h01);
      chk("bp_hold_chan", {5'b0, bus.out_chan}, 8'h03);
      chk("bp_hold_data", {4'b0, bus.out_data}, 8'h0C);
      chk("bp_hold_sel", sel_now(), 8'h03);
      chk("bp_hold_grant", bus.grant, 8'h00);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("bp_next_sel", sel_now(), 8'h07);
    tick();
    chk("bp_next_chan", {5'b0, bus.out_chan}, 8'h07);
    chk("bp_next_data", {4'b0, bus.out_data}, 8'h08);
    chk("bp_next_grant", bus.grant, 8'h80);

    // Asynchronous reset while holding valid data
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("arst_sel", sel_now(), 8'h00);
    chk("arst_grant", bus.grant, 8'h00);
    chk("arst_data", {4'b0, bus.out_data}, 8'h00);
    set_mux(1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", sel_now(), 8'h07);
    tick();
    chk("post_rst_chan", {5'b0, bus.out_chan}, 8'h07);
    chk("post_rst_data", {4'b0, bus.out_data}, 8'h07);
    chk("post_rst_grant", bus.grant, 8'h80);

    // Same lone requester is re-served
    tick();
    chk("repeat_sel", sel_now(), 8'h07);
    tick();
    chk("repeat_chan", {5'b0, bus.out_chan}, 8'h07);
    chk("repeat_grant", bus.grant, 8'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
